// File: rtl/expr_tx.sv
// Expression character-stream transmitter: serializes digit (op digit)* as ASCII over valid/ready.
// Optional request checking (n range, digits <= 9) is enabled by defining EXPR_TX_CHECK_EN.
module expr_tx #(
    parameter int unsigned MAXN = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic [3:0]              n,
    input  logic [4*MAXN-1:0]       digits,
    input  logic [2*(MAXN-1)-1:0]   ops,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDigit = 2'd1;
    localparam logic [1:0] StOp    = 2'd2;

    localparam logic [4:0] MaxnW = 5'(MAXN);

    logic [1:0]              state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic [3:0]              n_q, n_d;
    logic [4*MAXN-1:0]       digits_q, digits_d;
    logic [2*(MAXN-1)-1:0]   ops_q, ops_d;
    logic                    done_q, done_d;

    logic [3:0] digit_cur;
    logic [1:0] op_cur;
    logic       n_ok;
    logic       req_ok;
    logic       accept;
    logic       xfer;
    logic       is_last;

    // Operand/operator selection by the current index into the latched request.
    always_comb begin
        digit_cur = 4'd0;
        op_cur    = 2'd0;
        for (int i = 0; i < MAXN; i++) begin
            if (k_q == 4'(i)) digit_cur = digits_q[4*i +: 4];
        end
        for (int i = 0; i < MAXN - 1; i++) begin
            if (k_q == 4'(i)) op_cur = ops_q[2*i +: 2];
        end
    end

    assign n_ok = (n != 4'd0) && ({1'b0, n} <= MaxnW);

`ifdef EXPR_TX_CHECK_EN
    logic digits_ok;
    logic err_q, err_d;

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < MAXN; i++) begin
            if ((4'(i) < n) && (digits[4*i +: 4] > 4'd9)) digits_ok = 1'b0;
        end
    end

    assign req_ok = n_ok && digits_ok;

    always_comb begin
        err_d = 1'b0;
        if ((state_q == StIdle) && start && !req_ok) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign req_ok = n_ok;
    assign err    = 1'b0;
`endif

    assign accept  = (state_q == StIdle) && start && req_ok;
    assign xfer    = out_valid && out_ready;
    assign is_last = (k_q == n_q - 4'd1);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    n_d      = n;
                    digits_d = digits;
                    ops_d    = ops;
                    k_d      = 4'd0;
                    state_d  = StDigit;
                end
            end
            StDigit: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = StIdle;
                        k_d     = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StOp;
                    end
                end
            end
            StOp: begin
                if (xfer) begin
                    k_d     = k_q + 4'd1;
                    state_d = StDigit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StIdle;
            k_q      <= 4'd0;
            n_q      <= 4'd0;
            digits_q <= '0;
            ops_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (state_q)
            StDigit: out_data = 8'h30 + {4'd0, digit_cur};
            StOp: begin
                case (op_cur)
                    2'b00:   out_data = 8'h2B;
                    2'b01:   out_data = 8'h2D;
                    2'b10:   out_data = 8'h2A;
                    default: out_data = 8'h2F;
                endcase
            end
            default: out_data = 8'h00;
        endcase
    end

    assign out_valid = (state_q == StDigit) || (state_q == StOp);
    assign out_last  = (state_q == StDigit) && is_last;
    assign busy      = out_valid;
    assign done      = done_q;

endmodule

// File: tb/tb_expr_tx.sv
// Directed self-checking bench for expr_tx; expected characters are hand-computed ASCII.
module tb_expr_tx;

    localparam int unsigned MAXN = 8;

    logic                  clk = 1'b0;
    logic                  clr;
    logic                  start;
    logic [3:0]            n;
    logic [4*MAXN-1:0]     digits;
    logic [2*(MAXN-1)-1:0] ops;
    logic                  out_ready;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    expr_tx #(.MAXN(MAXN)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .n         (n),
        .digits    (digits),
        .ops       (ops),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Inputs change at the negedge; the request is seen at the following posedge.
    task automatic do_start(input logic [3:0] nv, input logic [31:0] dv, input logic [13:0] ov);
        n      = nv;
        digits = dv;
        ops    = ov;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Checks exp_q character by character with ready held high, then the done pulse.
    task automatic expect_stream(input string tag);
        int sz;
        sz = exp_q.size();
        for (int i = 0; i < sz; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s data[%0d]", tag, i), 32'(out_data), 32'(exp_q[i]));
            check($sformatf("%s last[%0d]", tag, i), 32'(out_last), 32'(i == sz - 1));
            @(negedge clk);
        end
        check($sformatf("%s done", tag), 32'(done), 32'd1);
        check($sformatf("%s busy_fall", tag), 32'(busy), 32'd0);
        check($sformatf("%s valid_fall", tag), 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] bp_data [8];
        logic       bp_rdy  [8];
        int         xfers;

        clr       = 1'b1;
        start     = 1'b0;
        n         = 4'd0;
        digits    = '0;
        ops       = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  32'(out_data),  32'h00);
        check("rst out_last",  32'(out_last),  32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst done",      32'(done),      32'd0);
        check("rst err",       32'(err),       32'd0);
        clr = 1'b0;
        @(negedge clk);

        // n=1, digit 7: single character, then done.
        do_start(4'd1, 32'h7, 14'h0);
        check("n1 busy", 32'(busy), 32'd1);
        exp_q = '{8'h37};
        expect_stream("n1");

        // Start accepted in the done cycle.
        do_start(4'd1, 32'h5, 14'h0);
        check("b2b done_low", 32'(done), 32'd0);
        exp_q = '{8'h35};
        expect_stream("b2b");
        @(negedge clk);
        check("b2b done_pulse_end", 32'(done), 32'd0);

        // n=3: 1+2*3
        do_start(4'd3, 32'h321, 14'h8);
        exp_q = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
        expect_stream("n3");

        // Same request with 3 cycles of backpressure on '2'.
        bp_data = '{8'h31, 8'h2B, 8'h32, 8'h32, 8'h32, 8'h32, 8'h2A, 8'h33};
        bp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        xfers   = 0;
        do_start(4'd3, 32'h321, 14'h8);
        for (int i = 0; i < 8; i++) begin
            out_ready = bp_rdy[i];
            check($sformatf("bp valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("bp data[%0d]", i), 32'(out_data), 32'(bp_data[i]));
            check($sformatf("bp last[%0d]", i), 32'(out_last), 32'(i == 7));
            if (out_valid && out_ready) xfers++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp transfers", 32'(xfers), 32'd5);
        check("bp done", 32'(done), 32'd1);

        // Start mid-stream with different operands is ignored: 9-8.
        do_start(4'd2, 32'h89, 14'h1);
        check("mid data0", 32'(out_data), 32'h39);
        n      = 4'd3;
        digits = 32'h111;
        ops    = 14'h3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_q = '{8'h2D, 8'h38};
        expect_stream("mid");

        // clr after 2nd transfer of 4-5/6 abandons the stream.
        do_start(4'd3, 32'h654, 14'hD);
        check("clr data0", 32'(out_data), 32'h34);
        @(negedge clk);
        check("clr data1", 32'(out_data), 32'h2D);
        @(negedge clk);
        check("clr data2", 32'(out_data), 32'h35);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr valid", 32'(out_valid), 32'd0);
        check("clr busy",  32'(busy),      32'd0);
        check("clr data",  32'(out_data),  32'h00);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("clr no_done[%0d]", i), 32'(done), 32'd0);
            @(negedge clk);
        end
        do_start(4'd3, 32'h654, 14'hD);
        exp_q = '{8'h34, 8'h2D, 8'h35, 8'h2F, 8'h36};
        expect_stream("restart");

        // clr and start together: clr wins.
        clr = 1'b1;
        do_start(4'd1, 32'h7, 14'h0);
        clr = 1'b0;
        check("clr_start valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("clr_start valid2", 32'(out_valid), 32'd0);

        // Out-of-range n is not accepted.
        do_start(4'd0, 32'h7, 14'h0);
        check("n0 valid", 32'(out_valid), 32'd0);
        check("n0 busy",  32'(busy),      32'd0);
`ifdef EXPR_TX_CHECK_EN
        check("n0 err", 32'(err), 32'd1);
`else
        check("n0 err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        check("n0 err_end", 32'(err), 32'd0);
        do_start(4'd9, 32'h7, 14'h0);
        check("n9 valid", 32'(out_valid), 32'd0);

        // Digit 0xA.
        @(negedge clk);
        do_start(4'd1, 32'hA, 14'h0);
`ifdef EXPR_TX_CHECK_EN
        check("hex err", 32'(err), 32'd1);
        check("hex valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("hex err_end", 32'(err), 32'd0);
        check("hex valid2", 32'(out_valid), 32'd0);
`else
        check("hex err", 32'(err), 32'd0);
        exp_q = '{8'h3A};
        expect_stream("hex");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_tx.md
# expr_tx

Expression character-stream transmitter. It takes a packed list of single-digit operands and binary operators and serializes them as 8-bit ASCII characters in the form digit (op digit)*, one character per accepted transfer. It is the source side of the character-stream expression checker, so a checker fed from this block reports a valid expression after the final character. It also drives character streams into other consumers via a valid/ready handshake.

## Interface
- MAXN, 8: maximum operand count (2..15).
- clk  in  1  clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- n  in  4  operand count for this request; valid range 1..MAXN.
- digits  in  4*MAXN  operand i at [4i+3:4i], i=0 sent first.
- ops  in  2*(MAXN-1)  operator i (between operand i and i+1) at [2i+1:2i]: 00 '+' (0x2B), 01 '-' (0x2D), 10 '*' (0x2A), 11 '/' (0x2F).
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds a character.
- out_data  out  8  ASCII character.
- out_last  out  1  current character is the final one of the expression.
- busy  out  1  high from the cycle after start is accepted until the last transfer completes.
- done  out  1  one-cycle pulse after the last transfer.
- err  out  1  one-cycle pulse on a rejected request. Tied 0 without EXPR_TX_CHECK_EN.

## Operation
- States: IDLE, DIGIT, OP.
- IDLE: on start with n in 1..MAXN, the block latches n, digits and ops, clears the operand index k to 0, and goes to DIGIT. With n outside 1..MAXN, start is ignored (err pulse only with the macro).
- DIGIT: out_data = 0x30 + digit[k]; out_last = (k == n-1). On transfer (out_valid & out_ready):
  - if last, go to IDLE;
  - otherwise go to OP.
- OP: out_data = operator code for ops[k]; out_last = 0. On transfer, k increments and the block goes to DIGIT.
- An expression is 2n-1 characters.
- out_valid = 1 in DIGIT and OP, 0 in IDLE.
- Latched inputs are used for the whole stream. Changes on digits/ops/n while busy have no effect.
- start while busy is ignored. It is not queued.
- A start is accepted in the same cycle done is high, because the block is already in IDLE.
- Digit mapping without the macro is raw: nibble values 10..15 emit 0x3A..0x3F.

## Timing
- Reset values: IDLE; out_valid 0, out_data 0x00, out_last 0, busy 0, done 0, err 0, k 0.
- Latency: start at cycle t gives out_valid=1 with the first character at t+1.
- Throughput: 1 character per cycle while out_ready=1. n operands with ready held high gives a stream of 2n-1 consecutive cycles.
- Backpressure: while out_valid & !out_ready, out_data and out_last hold stable. There is no skip and no duplicate.
- done is registered. It is high exactly in the cycle after the final transfer; busy falls in that same cycle.
- clr in any state: at the next edge the block is in IDLE with all outputs at reset values. A partial stream is abandoned with no out_last and no done.
- clr and start in the same cycle: clr wins.

## Configuration
- EXPR_TX_CHECK_EN defined: on start in IDLE, the request is rejected if n is outside 1..MAXN or any used digit (i < n) exceeds 9. On rejection:
  - err pulses 1 cycle at t+1;
  - no characters are emitted;
  - the block stays in IDLE.
- EXPR_TX_CHECK_EN undefined: err is constant 0. Invalid n is silently ignored, and digits are emitted with the raw mapping.

## Test plan
- n=1, digit0=7, ready=1 -> single cycle: out_data 0x37 with out_last=1; done at the next cycle.
- n=3, digits 1,2,3, ops 00,10, ready=1 -> 0x31,0x2B,0x32,0x2A,0x33 on 5 consecutive cycles, out_last on the 5th, then done.
- Same request with out_ready low 3 cycles while 0x32 is presented -> 0x32 held stable for 4 cycles, then 0x2A. Total 5 transfers.
- start pulsed again mid-stream with different operands -> ignored; the original stream completes unchanged.
- clr asserted after the 2nd transfer -> next cycle out_valid=0, busy=0, done never pulses. A new start then produces the full stream from operand 0.
- digit0=0xA, n=1:
  - with EXPR_TX_CHECK_EN: err pulse at t+1, out_valid stays 0.
  - without it: emits 0x3A with out_last=1.
